// File: rtl/button_event_queue_pkg.sv
// rtl/button_event_queue_pkg.sv - shared sizing constants and helpers for the button event queue
package button_event_queue_pkg;

  localparam int BTN_WIDTH      = 4;
  localparam int BTN_TS_WIDTH   = 16;
  localparam int BTN_FIFO_DEPTH = 8;
  localparam int DROP_CNT_W     = 8;

  // One FIFO entry is {timestamp, pulse vector}; the MMIO decode slices it the same way.
  localparam int BTN_ENTRY_W    = BTN_TS_WIDTH + BTN_WIDTH;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/button_event_queue_if.sv
// rtl/button_event_queue_if.sv - press-pulse input, event read port and overflow status bundle
interface button_event_queue_if #(
  parameter int WIDTH    = button_event_queue_pkg::BTN_WIDTH,
  parameter int DEPTH    = button_event_queue_pkg::BTN_FIFO_DEPTH,
  parameter int TS_WIDTH = button_event_queue_pkg::BTN_TS_WIDTH
) ();

  logic [WIDTH-1:0]           btn_pulse;
  logic                       evt_ready;
  logic                       clear_overflow;
  logic                       evt_valid;
  logic [WIDTH-1:0]           evt_buttons;
  logic [TS_WIDTH-1:0]        evt_timestamp;
  logic [$clog2(DEPTH):0]     count;
  logic                       overflow;
  logic [7:0]                 dropped_cnt;

  modport master (
    output btn_pulse, evt_ready, clear_overflow,
    input  evt_valid, evt_buttons, evt_timestamp, count, overflow, dropped_cnt
  );

  modport slave (
    input  btn_pulse, evt_ready, clear_overflow,
    output evt_valid, evt_buttons, evt_timestamp, count, overflow, dropped_cnt
  );

endinterface

// File: rtl/button_event_queue_fifo.sv
// rtl/button_event_queue_fifo.sv - first-word-fall-through synchronous FIFO, occupancy tracked by count
module sync_fifo_fwft #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  // Full and empty come from the count so wrapped, equal pointers are never ambiguous.
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_wr    = wr_en & (~full | rd_en);
    do_rd    = rd_en & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; the count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/button_event_queue.sv
// rtl/button_event_queue.sv - timestamps button press pulses and queues them for the CPU with drop tracking
module button_event_queue
  import button_event_queue_pkg::*;
#(
  parameter int WIDTH    = BTN_WIDTH,
  parameter int DEPTH    = BTN_FIFO_DEPTH,
  parameter int TS_WIDTH = BTN_TS_WIDTH
) (
  input logic                 clk,
  input logic                 rst_n,
  button_event_queue_if.slave bus
);

  localparam int ENTRY_W = TS_WIDTH + WIDTH;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] dropped_cnt_q, dropped_cnt_d;

  logic                  push_req, pop, accept, drop;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [ENTRY_W-1:0]    fifo_wr_data, fifo_rd_data;

  always_comb begin
    push_req     = |bus.btn_pulse;
    pop          = ~fifo_empty & bus.evt_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    accept       = push_req & (~fifo_full | pop);
    drop         = push_req & ~accept;
    fifo_wr_data = {ts_q, bus.btn_pulse};
    ts_d         = ts_q + TS_WIDTH'(1);

    overflow_d    = overflow_q;
    dropped_cnt_d = dropped_cnt_q;
    if (drop) begin
      overflow_d    = 1'b1;
      dropped_cnt_d = bus.clear_overflow ? DROP_CNT_W'(1) : sat_inc(dropped_cnt_q);
    end else if (bus.clear_overflow) begin
      overflow_d    = 1'b0;
      dropped_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q          <= '0;
      overflow_q    <= 1'b0;
      dropped_cnt_q <= '0;
    end else begin
      ts_q          <= ts_d;
      overflow_q    <= overflow_d;
      dropped_cnt_q <= dropped_cnt_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_data (fifo_wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bus.evt_valid     = ~fifo_empty;
  assign bus.evt_buttons   = fifo_empty ? '0 : fifo_rd_data[WIDTH-1:0];
  assign bus.evt_timestamp = fifo_empty ? '0 : fifo_rd_data[ENTRY_W-1:WIDTH];
  assign bus.count         = fifo_count;
  assign bus.overflow      = overflow_q;
  assign bus.dropped_cnt   = dropped_cnt_q;

endmodule

// File: tb/tb_button_event_queue.sv
// tb/tb_button_event_queue.sv - directed self-checking bench for button_event_queue
module tb_button_event_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cyc;
  logic [15:0] ts_exp [8];
  logic [3:0]  vec [20];
  logic [15:0] vts [20];
  int          total = 0;
  int          bad   = 0;

  button_event_queue_if bus ();

  button_event_queue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    if (rst_n) cyc = cyc + 16'd1;
    else       cyc = 16'd0;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [3:0] b, input logic [15:0] t);
    chk({tag, "_valid"}, 32'(bus.evt_valid), 32'd1);
    chk({tag, "_btn"},   32'(bus.evt_buttons), 32'(b));
    chk({tag, "_ts"},    32'(bus.evt_timestamp), 32'(t));
  endtask

  initial begin
    cyc                = 16'd0;
    rst_n              = 1'b0;
    bus.btn_pulse      = 4'($urandom_range(1, 15));
    bus.evt_ready      = 1'b0;
    bus.clear_overflow = 1'b0;
    @(negedge clk);

    // 1. reset with random pulses present
    step();
    bus.btn_pulse = 4'($urandom_range(1, 15));
    step();
    chk("rst_valid",    32'(bus.evt_valid), 32'd0);
    chk("rst_count",    32'(bus.count), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_dropped",  32'(bus.dropped_cnt), 32'd0);
    chk("rst_btn",      32'(bus.evt_buttons), 32'd0);
    chk("rst_ts",       32'(bus.evt_timestamp), 32'd0);

    // 2. single press at ts=5
    rst_n = 1'b1;
    bus.btn_pulse = 4'd0;
    repeat (5) step();
    bus.btn_pulse = 4'b0010;
    step();
    bus.btn_pulse = 4'd0;
    chk_head("single", 4'b0010, 16'd5);
    chk("single_count", 32'(bus.count), 32'd1);
    bus.evt_ready = 1'b1;
    step();
    bus.evt_ready = 1'b0;
    chk("single_pop_valid", 32'(bus.evt_valid), 32'd0);
    chk("single_pop_btn",   32'(bus.evt_buttons), 32'd0);
    bus.evt_ready = 1'b1;
    step();
    bus.evt_ready = 1'b0;
    chk("empty_ready_count", 32'(bus.count), 32'd0);

    // 3. fill, overflow by one, drain in order
    for (int i = 0; i < 8; i++) begin
      bus.btn_pulse = 4'(1 << (i % 4));
      ts_exp[i] = cyc;
      step();
    end
    chk("fill_count",    32'(bus.count), 32'd8);
    chk("fill_overflow", 32'(bus.overflow), 32'd0);
    bus.btn_pulse = 4'b0001;
    step();
    bus.btn_pulse = 4'd0;
    chk("ovf_overflow", 32'(bus.overflow), 32'd1);
    chk("ovf_dropped",  32'(bus.dropped_cnt), 32'd1);
    chk("ovf_count",    32'(bus.count), 32'd8);
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_head($sformatf("drain%0d", i), 4'(1 << (i % 4)), ts_exp[i]);
      step();
    end
    bus.evt_ready = 1'b0;
    chk("drain_valid", 32'(bus.evt_valid), 32'd0);
    chk("drain_count", 32'(bus.count), 32'd0);

    // 4. push into full FIFO while the head is popped
    for (int i = 0; i < 8; i++) begin
      bus.btn_pulse = 4'b0001;
      ts_exp[i] = cyc;
      step();
    end
    bus.btn_pulse = 4'b0100;
    bus.evt_ready = 1'b1;
    step();
    bus.btn_pulse = 4'd0;
    bus.evt_ready = 1'b0;
    chk("fullpop_count",   32'(bus.count), 32'd8);
    chk("fullpop_dropped", 32'(bus.dropped_cnt), 32'd1);
    chk_head("fullpop_head", 4'b0001, ts_exp[1]);

    // 5. saturation, clear, clear coinciding with a drop
    bus.btn_pulse = 4'b1111;
    repeat (300) step();
    bus.btn_pulse = 4'd0;
    chk("sat_dropped",  32'(bus.dropped_cnt), 32'd255);
    chk("sat_overflow", 32'(bus.overflow), 32'd1);
    chk("sat_count",    32'(bus.count), 32'd8);
    bus.clear_overflow = 1'b1;
    step();
    bus.clear_overflow = 1'b0;
    chk("clr_overflow", 32'(bus.overflow), 32'd0);
    chk("clr_dropped",  32'(bus.dropped_cnt), 32'd0);
    bus.clear_overflow = 1'b1;
    bus.btn_pulse = 4'b0010;
    step();
    bus.clear_overflow = 1'b0;
    bus.btn_pulse = 4'd0;
    chk("clrdrop_overflow", 32'(bus.overflow), 32'd1);
    chk("clrdrop_dropped",  32'(bus.dropped_cnt), 32'd1);

    // reset mid-operation discards the queue
    rst_n = 1'b0;
    step();
    chk("midrst_valid",    32'(bus.evt_valid), 32'd0);
    chk("midrst_count",    32'(bus.count), 32'd0);
    chk("midrst_overflow", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;

    // 6a. interleaved push/pop across pointer wrap
    for (int k = 0; k < 20; k++) begin
      vec[k] = 4'((k % 15) + 1);
      vts[k] = cyc;
      if (k > 0) chk_head($sformatf("ilv%0d", k), vec[k-1], vts[k-1]);
      bus.btn_pulse = vec[k];
      bus.evt_ready = (k > 0);
      step();
      chk($sformatf("ilv%0d_count", k), 32'(bus.count), 32'd1);
    end
    bus.btn_pulse = 4'd0;
    chk_head("ilv_last", vec[19], vts[19]);
    step();
    bus.evt_ready = 1'b0;
    chk("ilv_empty", 32'(bus.evt_valid), 32'd0);

    // 6b. timestamp wrap from 0xFFFF to 0x0000
    for (int n = 0; n < 70000 && cyc != 16'hFFFF; n++) step();
    chk("ts_reach_ffff", 32'(cyc), 32'h0000FFFF);
    bus.btn_pulse = 4'b0001;
    step();
    bus.btn_pulse = 4'b0010;
    step();
    bus.btn_pulse = 4'd0;
    chk("wrap_count", 32'(bus.count), 32'd2);
    chk_head("wrap_first", 4'b0001, 16'hFFFF);
    bus.evt_ready = 1'b1;
    step();
    bus.evt_ready = 1'b0;
    chk_head("wrap_second", 4'b0010, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
